font_rom_arbiter: RTL and testbench

Shares the single character-font ROM between two readers. The display path is the primary reader; an auxiliary reader, such as a text-buffer loader or a glyph preview, is the secondary one. The block sits between the requesters and the ROM controller's read port. It uses a four-phase request/acknowledge handshake per requester, fixed display priority, and a starvation guard that bounds how long the auxiliary reader can wait.

---
 rtl/font_rom_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_font_rom_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter
//
// Shares the single character-font ROM between the display path (primary
// reader) and an auxiliary reader (text-buffer loader, glyph preview, ...).
// Display has fixed priority. A starvation counter bounds how many
// back-to-back display grants can pass while aux is waiting. Once the bound
// is reached, aux wins the next arbitration.
//
// Handshake (both requesters): the requester raises req with a stable
// address and holds both until it sees a one-cycle ack. The data output is
// valid from the ack cycle and holds until that port's next ack. The
// requester must drop req on the clock edge where it samples ack. A req
// still high in the IDLE cycle after ACK counts as a new request. A req
// dropped mid-access does not abort the access; the ack still pulses.
//
// Ports:
//   clock      rising-edge clock for all logic
//   reset      synchronous, active-high; clears all state
//   dispReq    display request, held until dispAck
//   dispAddr   display address, stable while dispReq is high
//   dispAck    one-cycle pulse, dispData valid from this cycle
//   dispData   last byte returned to the display
//   auxReq     auxiliary request, same rules as dispReq
//   auxAddr    auxiliary address
//   auxAck     one-cycle pulse, auxData valid from this cycle
//   auxData    last byte returned to aux
//   romEn      ROM read enable, one-cycle pulse per access
//   romAddr    ROM address, holds the last issued value
//   romData    ROM read data, valid ROM_LAT cycles after romEn
//   auxStarve  starvation guard armed (starvation counter at STARVE_MAX)
//   stateDbg   current FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3)
//
// Access timeline for a request first seen in IDLE at cycle T:
//   T            grant, owner and address registered
//   T+1          ISSUE: romEn=1, romAddr valid
//   T+2..T+1+L   WAIT: romData captured in the last WAIT cycle
//   T+2+L        ACK: owner's ack pulses
//   T+3+L        IDLE: next arbitration
// -----------------------------------------------------------------------------
module font_rom_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 1,   // 1..7
    parameter int STARVE_MAX = 8    // 1..15
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              dispReq,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic              dispAck,
    output logic [DATA_W-1:0] dispData,

    input  logic              auxReq,
    input  logic [ADDR_W-1:0] auxAddr,
    output logic              auxAck,
    output logic [DATA_W-1:0] auxData,

    output logic              romEn,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [DATA_W-1:0] romData,

    output logic              auxStarve,
    output logic [1:0]        stateDbg
);

    localparam int WAIT_W   = 3;
    localparam int STARVE_W = 4;

    localparam logic [WAIT_W-1:0]   WAIT_LOAD    = WAIT_W'(ROM_LAT);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arbStateT;

    arbStateT state;
    arbStateT stateNext;

    // Owner of the access in flight: 0 = display, 1 = aux.
    logic                ownerAux;
    logic                ownerAuxNext;

    logic [WAIT_W-1:0]   waitCnt;
    logic [WAIT_W-1:0]   waitCntNext;

    logic [STARVE_W-1:0] starveCnt;
    logic [STARVE_W-1:0] starveCntNext;

    logic [ADDR_W-1:0]   romAddrNext;
    logic                romEnNext;
    logic                dispAckNext;
    logic                auxAckNext;
    logic [DATA_W-1:0]   dispDataNext;
    logic [DATA_W-1:0]   auxDataNext;

    logic                starveFull;
    logic                grantAux;
    logic                grantDisp;

    // ------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------
    // Aux wins when the display is not asking, or when the display has
    // already had STARVE_MAX consecutive grants while aux was waiting.
    assign starveFull = (starveCnt == STARVE_LIMIT);
    assign grantAux   = (state == IDLE) && auxReq && (!dispReq || starveFull);
    assign grantDisp  = (state == IDLE) && dispReq && !grantAux;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // romEn, the acks and the data registers are all registered. Their
    // next values are set one state early, so romEn is high exactly while
    // the FSM sits in ISSUE and the ack is high exactly while it sits in ACK.
    always_comb begin
        stateNext     = state;
        ownerAuxNext  = ownerAux;
        waitCntNext   = waitCnt;
        starveCntNext = starveCnt;
        romAddrNext   = romAddr;
        romEnNext     = 1'b0;
        dispAckNext   = 1'b0;
        auxAckNext    = 1'b0;
        dispDataNext  = dispData;
        auxDataNext   = auxData;

        case (state)
            IDLE: begin
                if (grantAux) begin
                    ownerAuxNext = 1'b1;
                    romAddrNext  = auxAddr;
                    romEnNext    = 1'b1;
                    stateNext    = ISSUE;
                end else if (grantDisp) begin
                    ownerAuxNext = 1'b0;
                    romAddrNext  = dispAddr;
                    romEnNext    = 1'b1;
                    stateNext    = ISSUE;
                end

                // The starvation count only measures display grants that
                // overtake a waiting aux request. It resets as soon as aux
                // is served or stops asking.
                if (!auxReq || grantAux) begin
                    starveCntNext = '0;
                end else if (grantDisp && !starveFull) begin
                    starveCntNext = starveCnt + 1'b1;
                end
            end

            ISSUE: begin
                waitCntNext = WAIT_LOAD;
                stateNext   = WAIT;
            end

            WAIT: begin
                waitCntNext = waitCnt - 1'b1;
                if (waitCnt == WAIT_W'(1)) begin
                    // Only the owner's data register and ack move. The
                    // other port keeps its last byte.
                    if (ownerAux) begin
                        auxDataNext = romData;
                        auxAckNext  = 1'b1;
                    end else begin
                        dispDataNext = romData;
                        dispAckNext  = 1'b1;
                    end
                    stateNext = ACK;
                end
            end

            ACK: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            ownerAux  <= 1'b0;
            waitCnt   <= '0;
            starveCnt <= '0;
            auxStarve <= 1'b0;
            romAddr   <= '0;
            romEn     <= 1'b0;
            dispAck   <= 1'b0;
            auxAck    <= 1'b0;
            dispData  <= '0;
            auxData   <= '0;
        end else begin
            ownerAux  <= ownerAuxNext;
            waitCnt   <= waitCntNext;
            starveCnt <= starveCntNext;
            // Registered from the counter's next value, so auxStarve always
            // equals (starveCnt == STARVE_MAX) in the same cycle.
            auxStarve <= (starveCntNext == STARVE_LIMIT);
            romAddr   <= romAddrNext;
            romEn     <= romEnNext;
            dispAck   <= dispAckNext;
            auxAck    <= auxAckNext;
            dispData  <= dispDataNext;
            auxData   <= auxDataNext;
        end
    end

    assign stateDbg = state;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_font_rom_arbiter
//
// Directed bench for font_rom_arbiter. Two instances are used: the main one
// with ROM_LAT=1 and STARVE_MAX=8, and a second with ROM_LAT=3. Each ROM
// model returns ~{0,addr} exactly ROM_LAT cycles after romEn. Outside that
// window it returns 0x5A, so a capture in the wrong cycle shows up as wrong
// data. Inputs are driven 1 time unit after the rising edge. Outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_font_rom_arbiter;

    localparam int AW = 7;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- main DUT (ROM_LAT=1) ----------------
    logic          dispReq, auxReq;
    logic [AW-1:0] dispAddr, auxAddr;
    logic          dispAck, auxAck, romEn, auxStarve;
    logic [DW-1:0] dispData, auxData, romData;
    logic [AW-1:0] romAddr;
    logic [1:0]    stateDbg;

    font_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .STARVE_MAX(8)) u_dut (
        .clock(clock), .reset(reset),
        .dispReq(dispReq), .dispAddr(dispAddr), .dispAck(dispAck), .dispData(dispData),
        .auxReq(auxReq), .auxAddr(auxAddr), .auxAck(auxAck), .auxData(auxData),
        .romEn(romEn), .romAddr(romAddr), .romData(romData),
        .auxStarve(auxStarve), .stateDbg(stateDbg)
    );

    always @(posedge clock) romData <= romEn ? ~{1'b0, romAddr} : 8'h5A;

    // ---------------- second DUT (ROM_LAT=3) ----------------
    logic          bDispReq, bAuxReq;
    logic [AW-1:0] bDispAddr, bAuxAddr;
    logic          bDispAck, bAuxAck, bRomEn, bAuxStarve;
    logic [DW-1:0] bDispData, bAuxData, bRomData;
    logic [AW-1:0] bRomAddr;
    logic [1:0]    bStateDbg;
    logic [DW-1:0] bPipe0, bPipe1;

    font_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3), .STARVE_MAX(8)) u_dut3 (
        .clock(clock), .reset(reset),
        .dispReq(bDispReq), .dispAddr(bDispAddr), .dispAck(bDispAck), .dispData(bDispData),
        .auxReq(bAuxReq), .auxAddr(bAuxAddr), .auxAck(bAuxAck), .auxData(bAuxData),
        .romEn(bRomEn), .romAddr(bRomAddr), .romData(bRomData),
        .auxStarve(bAuxStarve), .stateDbg(bStateDbg)
    );

    always @(posedge clock) begin
        bPipe0   <= bRomEn ? ~{1'b0, bRomAddr} : 8'h5A;
        bPipe1   <= bPipe0;
        bRomData <= bPipe1;
    end

    // ---------------- checking ----------------
    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard for the main DUT ----------------
    // Entry: {valid, isAux, data}. Every ack on the main DUT must match the
    // head of the queue. An empty queue yields 0, so a stray ack mismatches.
    logic [DW+1:0] expQ[$];
    int            nDispAck = 0;

    always @(negedge clock) begin
        if (!reset && (dispAck || auxAck)) begin
            logic [DW+1:0] expEntry;
            expEntry = (expQ.size() > 0) ? expQ.pop_front() : '0;
            if (dispAck) nDispAck++;
            checkVal("sb_ack", 32'({1'b1, auxAck, auxAck ? auxData : dispData}), 32'(expEntry));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clock);
    endtask

    task automatic driveDisp(input logic req, input logic [AW-1:0] addr);
        dispReq  = req;
        dispAddr = addr;
    endtask

    task automatic driveAux(input logic req, input logic [AW-1:0] addr);
        auxReq  = req;
        auxAddr = addr;
    endtask

    task automatic expectAck(input logic isAux, input logic [DW-1:0] data);
        expQ.push_back({1'b1, isAux, data});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int dispBase;

    initial begin
        // ---- reset with random inputs for 3 cycles ----
        reset = 1'b1;
        dispReq  = 1'($urandom_range(0, 1));
        auxReq   = 1'($urandom_range(0, 1));
        dispAddr = 7'($urandom_range(0, 127));
        auxAddr  = 7'($urandom_range(0, 127));
        bDispReq = 1'b0; bAuxReq = 1'b0; bDispAddr = '0; bAuxAddr = '0;
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            midCycle();
            checkVal("rst_dispAck",   32'(dispAck),   0);
            checkVal("rst_auxAck",    32'(auxAck),    0);
            checkVal("rst_dispData",  32'(dispData),  0);
            checkVal("rst_auxData",   32'(auxData),   0);
            checkVal("rst_romEn",     32'(romEn),     0);
            checkVal("rst_romAddr",   32'(romAddr),   0);
            checkVal("rst_auxStarve", 32'(auxStarve), 0);
            checkVal("rst_state",     32'(stateDbg),  0);
            nextCycle();
            dispReq  = 1'($urandom_range(0, 1));
            auxReq   = 1'($urandom_range(0, 1));
            dispAddr = 7'($urandom_range(0, 127));
            auxAddr  = 7'($urandom_range(0, 127));
        end
        reset = 1'b0;
        driveDisp(1'b0, '0);
        driveAux(1'b0, '0);
        nextCycle();
        nextCycle();

        // ---- single display read, addr 0x35 -> 0xCA at T+3 ----
        driveDisp(1'b1, 7'h35);                 // T
        expectAck(1'b0, 8'hCA);
        nextCycle(); midCycle();                // T+1
        checkVal("d1_romEn",   32'(romEn),   1);
        checkVal("d1_romAddr", 32'(romAddr), 'h35);
        dispAddr = 7'h00;                       // must not disturb the access
        nextCycle(); midCycle();                // T+2
        checkVal("d1_romEn_pulse", 32'(romEn),   0);
        checkVal("d1_romAddr_hold", 32'(romAddr), 'h35);
        checkVal("d1_noearly_ack", 32'(dispAck), 0);
        nextCycle(); midCycle();                // T+3
        checkVal("d1_dispAck",  32'(dispAck),  1);
        checkVal("d1_dispData", 32'(dispData), 'hCA);
        checkVal("d1_auxAck",   32'(auxAck),   0);
        checkVal("d1_auxData",  32'(auxData),  0);
        dispReq = 1'b0;
        nextCycle(); midCycle();                // T+4
        checkVal("d1_ack_pulse", 32'(dispAck),  0);
        checkVal("d1_idle",      32'(stateDbg), 0);
        nextCycle();

        // ---- simultaneous requests: display first, then aux ----
        driveDisp(1'b1, 7'h10);                 // T
        driveAux(1'b1, 7'h22);
        expectAck(1'b0, 8'hEF);
        expectAck(1'b1, 8'hDD);
        nextCycle(); midCycle();                // T+1
        checkVal("sim_romAddr_disp", 32'(romAddr), 'h10);
        nextCycle();                            // T+2
        nextCycle(); midCycle();                // T+3
        checkVal("sim_dispAck",  32'(dispAck),  1);
        checkVal("sim_dispData", 32'(dispData), 'hEF);
        dispReq = 1'b0;
        nextCycle();                            // T+4 aux grant
        nextCycle(); midCycle();                // T+5
        checkVal("sim_romEn_aux",   32'(romEn),   1);
        checkVal("sim_romAddr_aux", 32'(romAddr), 'h22);
        nextCycle();                            // T+6
        nextCycle(); midCycle();                // T+7
        checkVal("sim_auxAck",        32'(auxAck),   1);
        checkVal("sim_auxData",       32'(auxData),  'hDD);
        checkVal("sim_dispData_kept", 32'(dispData), 'hEF);
        checkVal("sim_dispAck_low",   32'(dispAck),  0);
        auxReq = 1'b0;
        nextCycle(); midCycle();                // T+8
        checkVal("sim_idle", 32'(stateDbg), 0);
        nextCycle();

        // ---- starvation: display requests continuously, aux held ----
        // Display grant k at cycle 4(k-1), ack at 4k-1. Aux wins grant 9
        // at cycle 32 (ack 35). Display is served again at 36 (ack 39).
        driveDisp(1'b1, 7'h02);
        driveAux(1'b1, 7'h01);
        for (int k = 0; k < 8; k++) expectAck(1'b0, 8'hFD);
        expectAck(1'b1, 8'hFE);
        expectAck(1'b0, 8'hFD);
        dispBase = nDispAck;
        for (int c = 0; c < 40; c++) begin
            midCycle();
            if (c == 27) checkVal("stv_starve_after7", 32'(auxStarve), 0);
            if (c == 31) begin
                checkVal("stv_dispAck8",      32'(dispAck),   1);
                checkVal("stv_starve_after8", 32'(auxStarve), 1);
            end
            if (c == 33) begin
                checkVal("stv_romEn_aux",   32'(romEn),   1);
                checkVal("stv_romAddr_aux", 32'(romAddr), 'h01);
            end
            if (c == 35) begin
                checkVal("stv_auxAck",         32'(auxAck),               1);
                checkVal("stv_auxData",        32'(auxData),              'hFE);
                checkVal("stv_starve_cleared", 32'(auxStarve),            0);
                checkVal("stv_dispAck_count",  32'(nDispAck - dispBase),  8);
                auxReq = 1'b0;
            end
            if (c == 39) begin
                checkVal("stv_disp_after_aux", 32'(dispAck), 1);
                dispReq = 1'b0;
            end
            nextCycle();
        end

        // ---- reset during WAIT of a display access ----
        driveDisp(1'b1, 7'h44);                 // R
        nextCycle();                            // R+1
        nextCycle(); midCycle();                // R+2
        checkVal("ra_in_wait", 32'(stateDbg), 2);
        reset   = 1'b1;
        dispReq = 1'b0;
        nextCycle(); midCycle();                // R+3
        checkVal("ra_state",    32'(stateDbg), 0);
        checkVal("ra_dispAck",  32'(dispAck),  0);
        checkVal("ra_romEn",    32'(romEn),    0);
        checkVal("ra_dispData", 32'(dispData), 0);
        checkVal("ra_auxData",  32'(auxData),  0);
        reset = 1'b0;
        nextCycle(); midCycle();                // R+4
        checkVal("ra_no_late_ack", 32'(dispAck), 0);
        nextCycle();

        driveDisp(1'b1, 7'h35);                 // N
        expectAck(1'b0, 8'hCA);
        nextCycle(); midCycle();                // N+1
        checkVal("ra2_romEn",   32'(romEn),   1);
        checkVal("ra2_romAddr", 32'(romAddr), 'h35);
        nextCycle();                            // N+2
        nextCycle(); midCycle();                // N+3
        checkVal("ra2_dispAck",  32'(dispAck),  1);
        checkVal("ra2_dispData", 32'(dispData), 'hCA);
        dispReq = 1'b0;
        nextCycle();

        // ---- ROM_LAT=3 instance: aux 0x7F -> 0x80 at T+5 ----
        bAuxReq  = 1'b1;                        // T
        bAuxAddr = 7'h7F;
        nextCycle(); midCycle();                // T+1
        checkVal("l3_romEn",   32'(bRomEn),   1);
        checkVal("l3_romAddr", 32'(bRomAddr), 'h7F);
        nextCycle();                            // T+2
        nextCycle();                            // T+3
        nextCycle(); midCycle();                // T+4
        checkVal("l3_no_early_ack", 32'(bAuxAck), 0);
        nextCycle(); midCycle();                // T+5
        checkVal("l3_auxAck",   32'(bAuxAck),   1);
        checkVal("l3_auxData",  32'(bAuxData),  'h80);
        checkVal("l3_dispData", 32'(bDispData), 0);
        checkVal("l3_dispAck",  32'(bDispAck),  0);
        bAuxReq = 1'b0;
        nextCycle(); midCycle();                // T+6
        checkVal("l3_ack_pulse", 32'(bAuxAck),   0);
        checkVal("l3_idle",      32'(bStateDbg), 0);
        nextCycle();

        // ---- final report ----
        checkVal("sb_drained", 32'(expQ.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
